tdm_demux_2bit: RTL and testbench

Sequential time-division demultiplexer: receives a framed stream of 2-bit words, alternating channel X then channel Y, and steers each word into its own registered output with a one-cycle valid strobe. It is the receive end of the 2:1 word selector path. A transmitter interleaves the two sources onto one bus, and this block separates them again. On the board it sits between the switch-driven source logic and the LEDR displays.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_chan_reg.sv | 38 +++
 rtl/tdm_demux_2bit.sv | 130 +++++++++++++
 tb/tb_tdm_demux_2bit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the 2-bit TDM demultiplexer.
//   - tdm_state_e : frame-alignment FSM states
//   - TDM_WIDTH   : default word width
//   - ERRCNT_W / ERRCNT_MAX : framing-error counter width and saturation value
package tdm_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    WAIT_Y   = 2'd1,
    WAIT_X   = 2'd2
  } tdm_state_e;

  localparam int TDM_WIDTH = 2;

  localparam int                ERRCNT_W   = 8;
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'hFF;

endpackage

// File: rtl/tdm_chan_reg.sv
// tdm_chan_reg: per-channel hold register.
// Ports:
//   clk    in  system clock
//   resetn in  synchronous active-low reset
//   load   in  capture d this cycle
//   d      in  data to capture
//   q      out held data (keeps its value until the next load)
//   valid  out one-cycle pulse following each load
module tdm_chan_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= load;
      if (load) begin
        r_q <= d;
      end
    end
  end

  assign q     = r_q;
  assign valid = r_valid;

endmodule

// File: rtl/tdm_demux_2bit.sv
// tdm_demux_2bit: splits an interleaved X/Y stream of words into two
// registered channel outputs with one-cycle valid strobes. sync marks the
// X word of each frame; a frame is X followed by Y.
// Optional feature macro: TDM_DEMUX_ERRCNT_EN (saturating framing-error
// counter on err_count; when undefined err_count is tied to zero).
// Ports:
//   clk, resetn (sync, active-low)
//   din[WIDTH], din_valid, sync      : incoming TDM stream
//   x_out/x_valid, y_out/y_valid     : demultiplexed channels
//   locked                           : frame alignment held
//   frame_err                        : one-cycle framing-violation pulse
//   err_count[8]                     : saturating error count
module tdm_demux_2bit
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    din,
  input  logic                din_valid,
  input  logic                sync,
  output logic [WIDTH-1:0]    x_out,
  output logic [WIDTH-1:0]    y_out,
  output logic                x_valid,
  output logic                y_valid,
  output logic                locked,
  output logic                frame_err,
  output logic [ERRCNT_W-1:0] err_count
);

  tdm_state_e r_state;
  tdm_state_e w_state_next;
  logic       r_locked;
  logic       r_frame_err;
  logic       w_x_load;
  logic       w_y_load;
  logic       w_err;

  // Decode of the accepted word: which channel captures it, whether it
  // violates framing, and where alignment goes next.
  always_comb begin
    w_x_load     = 1'b0;
    w_y_load     = 1'b0;
    w_err        = 1'b0;
    w_state_next = r_state;
    if (din_valid) begin
      case (r_state)
        UNLOCKED: begin
          // Unsynchronised words are silently dropped until a marker shows up.
          if (sync) begin
            w_x_load     = 1'b1;
            w_state_next = WAIT_Y;
          end
        end
        WAIT_Y: begin
          if (sync) begin
            // Early marker: flag it but treat the word as a fresh X.
            w_err    = 1'b1;
            w_x_load = 1'b1;
          end else begin
            w_y_load     = 1'b1;
            w_state_next = WAIT_X;
          end
        end
        WAIT_X: begin
          if (sync) begin
            w_x_load     = 1'b1;
            w_state_next = WAIT_Y;
          end else begin
            w_err        = 1'b1;
            w_state_next = UNLOCKED;
          end
        end
        default: w_state_next = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= UNLOCKED;
      r_locked    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_locked    <= (w_state_next != UNLOCKED);
      r_frame_err <= w_err;
    end
  end

  tdm_chan_reg #(.WIDTH(WIDTH)) u_chan_x (
    .clk    (clk),
    .resetn (resetn),
    .load   (w_x_load),
    .d      (din),
    .q      (x_out),
    .valid  (x_valid)
  );

  tdm_chan_reg #(.WIDTH(WIDTH)) u_chan_y (
    .clk    (clk),
    .resetn (resetn),
    .load   (w_y_load),
    .d      (din),
    .q      (y_out),
    .valid  (y_valid)
  );

  assign locked    = r_locked;
  assign frame_err = r_frame_err;

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_count;

  // Counts alongside the frame_err register so both update on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err_count <= '0;
    end else if (w_err && (r_err_count != ERRCNT_MAX)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_tdm_demux_2bit.sv
// tb_tdm_demux_2bit: self-checking bench for tdm_demux_2bit. Directed
// frame sequences followed by randomized traffic, all checked every cycle
// against a frame-level reference model.
module tb_tdm_demux_2bit;

  logic       clk;
  logic       resetn;
  logic [1:0] din;
  logic       din_valid;
  logic       sync;
  logic [1:0] x_out;
  logic [1:0] y_out;
  logic       x_valid;
  logic       y_valid;
  logic       locked;
  logic       frame_err;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  tdm_demux_2bit #(.WIDTH(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .x_out     (x_out),
    .y_out     (y_out),
    .x_valid   (x_valid),
    .y_valid   (y_valid),
    .locked    (locked),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks whether alignment is held and, if so, which
  // word of the frame comes next. Outputs are the expected register values.
  bit         m_aligned;
  bit         m_need_y;
  logic [1:0] m_x, m_y;
  bit         m_xv, m_yv, m_fe;
  int         m_errs;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit rn, input bit v, input bit s, input logic [1:0] d);
    if (!rn) begin
      m_aligned = 0; m_need_y = 0;
      m_x = 2'b00; m_y = 2'b00;
      m_xv = 0; m_yv = 0; m_fe = 0;
      m_errs = 0;
      return;
    end
    m_xv = 0; m_yv = 0; m_fe = 0;
    if (!v) return;
    if (s) begin
      // A marker always starts a new frame; it is an error only if a Y was owed.
      if (m_aligned && m_need_y) begin
        m_fe = 1;
        m_errs++;
      end
      m_x = d; m_xv = 1;
      m_aligned = 1; m_need_y = 1;
    end else if (m_aligned && m_need_y) begin
      m_y = d; m_yv = 1;
      m_need_y = 0;
    end else if (m_aligned) begin
      // An X was owed but no marker arrived: alignment is lost.
      m_fe = 1;
      m_errs++;
      m_aligned = 0;
    end
  endtask

  function automatic logic [7:0] exp_count();
`ifdef TDM_DEMUX_ERRCNT_EN
    return (m_errs > 255) ? 8'hFF : 8'(m_errs);
`else
    return 8'h00;
`endif
  endfunction

  task automatic step(input bit rn, input bit v, input bit s, input logic [1:0] d);
    resetn = rn; din_valid = v; sync = s; din = d;
    @(posedge clk);
    #1;
    model_step(rn, v, s, d);
    $display("txn t=%0t rn=%0b v=%0b s=%0b d=%0b | x=%0b/%0b y=%0b/%0b lk=%0b fe=%0b ec=%0d",
             $time, rn, v, s, d, x_out, x_valid, y_out, y_valid, locked, frame_err, err_count);
    check("x_out",     8'(x_out),     8'(m_x));
    check("y_out",     8'(y_out),     8'(m_y));
    check("x_valid",   8'(x_valid),   8'(m_xv));
    check("y_valid",   8'(y_valid),   8'(m_yv));
    check("locked",    8'(locked),    8'(m_aligned));
    check("frame_err", 8'(frame_err), 8'(m_fe));
    check("err_count", err_count,     exp_count());
  endtask

  initial begin
    resetn = 1'b0; din_valid = 1'b1; sync = 1'b1; din = 2'b11;

    // Reset held with a live word on the bus.
    repeat (3) step(0, 1, 1, 2'b11);

    // Normal frames back-to-back, first word right after reset release.
    step(1, 1, 1, 2'b01);
    step(1, 1, 0, 2'b10);
    step(1, 1, 1, 2'b11);
    step(1, 1, 0, 2'b00);

    // Gap between X and Y.
    step(1, 1, 1, 2'b10);
    step(1, 0, 0, 2'b11);
    step(1, 0, 1, 2'b00);
    step(1, 1, 0, 2'b01);

    // Early sync in WAIT_Y.
    step(1, 1, 1, 2'b01);
    step(1, 1, 1, 2'b11);
    step(1, 1, 0, 2'b10);

    // Missing sync in WAIT_X, then ignored unsynchronised words.
    step(1, 1, 0, 2'b10);
    step(1, 1, 0, 2'b01);
    step(1, 1, 0, 2'b11);
    step(1, 1, 1, 2'b00);

    // Repeated early markers drive the error count past saturation.
    for (int i = 0; i < 260; i++) step(1, 1, 1, 2'(i));
    // Mid-frame reset (X taken, Y owed).
    step(1, 1, 0, 2'b01);
    step(1, 1, 1, 2'b10);
    step(0, 1, 0, 2'b11);
    step(1, 1, 0, 2'b01);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? ~m_need_y : 1'($urandom), 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
